servo_ramp_ctrl: RTL and testbench

//   Motion-profile stage directly upstream of the servo PWM generator in the arm.

---
 rtl/servo_ramp_ctrl_pkg.sv | 21 ++
 rtl/servo_ramp_ctrl_if.sv | 25 ++
 rtl/servo_ramp_ctrl_step_tick.sv | 31 +++
 rtl/servo_ramp_ctrl.sv | 127 ++++++++++++
 tb/tb_servo_ramp_ctrl.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/servo_ramp_ctrl_pkg.sv
// Shared servo definitions: position width, legal range, home position and the
// ramp controller state encoding. Also used by the PWM and the command decoder.
package servo_pkg;

    localparam int POS_W = 16;

    localparam logic [POS_W-1:0] MAX_POS  = 16'd85;
    localparam logic [POS_W-1:0] HOME_POS = 16'd8;

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        IDLE = 2'd1,
        MOVE = 2'd2
    } state_t;

    // The PWM scales data*3 into 0..255, so anything above MAX_POS would wrap the duty.
    function automatic logic [POS_W-1:0] clamp_pos(input logic [POS_W-1:0] target);
        return (target > MAX_POS) ? MAX_POS : target;
    endfunction

endpackage

// File: rtl/servo_ramp_ctrl_if.sv
// Target-position command port: valid/ready handshake carrying a target or an off request.
interface servo_ramp_ctrl_if
    import servo_pkg::*;
;

    logic             cmd_valid;
    logic             cmd_ready;
    logic [POS_W-1:0] cmd_target;
    logic             cmd_off;

    modport master (
        output cmd_valid,
        output cmd_target,
        output cmd_off,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_target,
        input  cmd_off,
        output cmd_ready
    );

endinterface

// File: rtl/servo_ramp_ctrl_step_tick.sv
// Restartable free-running counter; o_tick pulses on the cycle the count wraps
// from STEP_CYCLES-1 back to 0. Held at zero while i_clr is high.
module step_tick #(
    parameter int STEP_CYCLES = 500_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    output logic o_tick
);

    localparam int                CNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(STEP_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr || r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick = !i_clr && (r_cnt == LAST);

endmodule

// File: rtl/servo_ramp_ctrl.sv
// Motion-profile stage ahead of the servo PWM: slews the position toward each
// commanded target by at most STEP_SIZE every STEP_CYCLES clocks.
module servo_ramp_ctrl
    import servo_pkg::*;
#(
    parameter int STEP_CYCLES = 500_000,
    parameter int STEP_SIZE   = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    servo_ramp_ctrl_if.slave     bus,
    input  logic                 i_stop,
    output logic [POS_W-1:0]     o_pos_out,
    output logic                 o_pwm_en,
    output logic                 o_busy,
    output logic                 o_done
);

    localparam logic [POS_W:0] STEP_MAG = (POS_W + 1)'(STEP_SIZE);

    state_t           r_state;
    logic [POS_W-1:0] r_pos;
    logic [POS_W-1:0] r_tgt;
    logic             r_done;
    logic             r_cmd_ready;
    logic             r_busy;
    logic             r_pwm_en;

    state_t           w_next_state;
    logic [POS_W-1:0] w_next_pos;
    logic [POS_W-1:0] w_next_tgt;
    logic             w_next_done;
    logic             w_accept;
    logic             w_tick;
    logic [POS_W-1:0] w_cmd_tgt;

    logic signed [POS_W:0] w_diff;
    logic [POS_W:0]        w_mag;
    logic [POS_W-1:0]      w_step;
    logic [POS_W-1:0]      w_step_pos;

    step_tick #(
        .STEP_CYCLES (STEP_CYCLES)
    ) u_step_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (r_state != MOVE),
        .o_tick (w_tick)
    );

    assign w_accept  = bus.cmd_valid && r_cmd_ready;
    assign w_cmd_tgt = clamp_pos(bus.cmd_target);

    // Signed difference gives direction; the step is the smaller of STEP_SIZE
    // and the remaining distance, so the position can never pass the target.
    assign w_diff     = $signed({1'b0, r_tgt}) - $signed({1'b0, r_pos});
    assign w_mag      = w_diff[POS_W] ? $unsigned(-w_diff) : $unsigned(w_diff);
    assign w_step     = (w_mag > STEP_MAG) ? STEP_MAG[POS_W-1:0] : w_mag[POS_W-1:0];
    assign w_step_pos = w_diff[POS_W] ? (r_pos - w_step) : (r_pos + w_step);

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_next_pos   = r_pos;
        w_next_tgt   = r_tgt;
        w_next_done  = 1'b0;
        case (r_state)
            OFF, IDLE: begin
                if (w_accept) begin
                    if (bus.cmd_off) begin
                        w_next_state = OFF;
                    end else begin
                        w_next_tgt = w_cmd_tgt;
                        if (w_cmd_tgt == r_pos) begin
                            w_next_state = IDLE;
                            w_next_done  = 1'b1;
                        end else begin
                            w_next_state = MOVE;
                        end
                    end
                end
            end
            MOVE: begin
                // Stop beats a coinciding tick: the position freezes un-stepped.
                if (i_stop) begin
                    w_next_state = IDLE;
                    w_next_done  = 1'b1;
                end else if (w_tick) begin
                    w_next_pos = w_step_pos;
                    if (w_step_pos == r_tgt) begin
                        w_next_state = IDLE;
                        w_next_done  = 1'b1;
                    end
                end
            end
            default: w_next_state = OFF;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= OFF;
            r_pos       <= HOME_POS;
            r_tgt       <= HOME_POS;
            r_done      <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_pwm_en    <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_pos       <= w_next_pos;
            r_tgt       <= w_next_tgt;
            r_done      <= w_next_done;
            r_cmd_ready <= (w_next_state != MOVE);
            r_busy      <= (w_next_state == MOVE);
            r_pwm_en    <= (w_next_state != OFF);
        end
    end

    assign bus.cmd_ready = r_cmd_ready;
    assign o_pos_out     = r_pos;
    assign o_pwm_en      = r_pwm_en;
    assign o_busy        = r_busy;
    assign o_done        = r_done;

endmodule

// File: tb/tb_servo_ramp_ctrl.sv
// Directed bench for servo_ramp_ctrl with STEP_CYCLES=4: a vector table for the
// basic ramp plus hand-written sequences for clamp, stop, handshake, off and reset.
module tb_servo_ramp_ctrl;
    import servo_pkg::*;

    localparam int STEP_CYCLES = 4;

    logic             clk;
    logic             rst_n;
    logic             stop;
    logic [POS_W-1:0] pos_out;
    logic             pwm_en;
    logic             busy;
    logic             done;

    int n_checks = 0;
    int n_errors = 0;

    servo_ramp_ctrl_if bus ();

    servo_ramp_ctrl #(
        .STEP_CYCLES (STEP_CYCLES),
        .STEP_SIZE   (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave),
        .i_stop    (stop),
        .o_pos_out (pos_out),
        .o_pwm_en  (pwm_en),
        .o_busy    (busy),
        .o_done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int               edge_no;
        logic [POS_W-1:0] pos;
        logic             busy;
        logic             done;
        logic             ready;
        logic             pwm_en;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick_clk();
        @(posedge clk);
        #1;
    endtask

    // Presents one command for exactly one edge; only used when cmd_ready is high.
    task automatic issue_cmd(input logic [POS_W-1:0] target, input logic off);
        bus.cmd_valid  = 1'b1;
        bus.cmd_target = target;
        bus.cmd_off    = off;
        tick_clk();
        bus.cmd_valid  = 1'b0;
        bus.cmd_off    = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cycles, output int lo, output int hi);
        cycles = -1;
        lo     = int'(pos_out);
        hi     = int'(pos_out);
        for (int i = 1; i <= budget; i++) begin
            tick_clk();
            if (int'(pos_out) < lo) lo = int'(pos_out);
            if (int'(pos_out) > hi) hi = int'(pos_out);
            if (done) begin
                cycles = i;
                break;
            end
        end
        if (cycles < 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL wait_done: no done within %0d cycles (t=%0t)", budget, $time);
        end
    endtask

    initial begin
        int cur;
        int cycles;
        int lo;
        int hi;

        vecs[0] = '{0,  16'd8,  1'b1, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{3,  16'd8,  1'b1, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{4,  16'd9,  1'b1, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{7,  16'd9,  1'b1, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{8,  16'd10, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{12, 16'd11, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{15, 16'd11, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[7] = '{16, 16'd12, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[8] = '{17, 16'd12, 1'b0, 1'b0, 1'b1, 1'b1};

        rst_n          = 1'b0;
        stop           = 1'b0;
        bus.cmd_valid  = 1'b0;
        bus.cmd_target = '0;
        bus.cmd_off    = 1'b0;

        // Power-up reset state
        repeat (2) tick_clk();
        check("rst_pos", 32'(pos_out), 32'd8);
        check("rst_pwm_en", 32'(pwm_en), 32'd0);
        check("rst_ready", 32'(bus.cmd_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        tick_clk();

        // Basic ramp 8 -> 12 from OFF, table-driven
        issue_cmd(16'd12, 1'b0);
        cur = 0;
        for (int i = 0; i < 9; i++) begin
            while (cur < vecs[i].edge_no) begin
                tick_clk();
                cur++;
            end
            check($sformatf("ramp_pos@%0d", cur), 32'(pos_out), 32'(vecs[i].pos));
            check($sformatf("ramp_busy@%0d", cur), 32'(busy), 32'(vecs[i].busy));
            check($sformatf("ramp_done@%0d", cur), 32'(done), 32'(vecs[i].done));
            check($sformatf("ramp_ready@%0d", cur), 32'(bus.cmd_ready), 32'(vecs[i].ready));
            check($sformatf("ramp_en@%0d", cur), 32'(pwm_en), 32'(vecs[i].pwm_en));
        end

        // Clamp: 200 -> 85, 73 steps of 4 cycles
        issue_cmd(16'd200, 1'b0);
        wait_done(400, cycles, lo, hi);
        check("clamp_cycles", 32'(cycles), 32'd292);
        check("clamp_pos", 32'(pos_out), 32'd85);
        check("clamp_max", 32'(hi), 32'd85);

        // Reverse 85 -> 83 without overshoot
        issue_cmd(16'd83, 1'b0);
        wait_done(40, cycles, lo, hi);
        check("rev_cycles", 32'(cycles), 32'd8);
        check("rev_pos", 32'(pos_out), 32'd83);
        check("rev_min", 32'(lo), 32'd83);

        // Asynchronous reset in the middle of a move and mid-cycle
        issue_cmd(16'd0, 1'b0);
        repeat (6) tick_clk();
        check("pre_rst_pos", 32'(pos_out), 32'd82);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_pos", 32'(pos_out), 32'd8);
        check("async_rst_en", 32'(pwm_en), 32'd0);
        check("async_rst_ready", 32'(bus.cmd_ready), 32'd1);
        check("async_rst_busy", 32'(busy), 32'd0);
        tick_clk();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick_clk();
            check("post_rst_done", 32'(done), 32'd0);
            check("post_rst_pos", 32'(pos_out), 32'd8);
        end

        // Stop on the same edge as the third tick of 8 -> 20
        issue_cmd(16'd20, 1'b0);
        repeat (11) tick_clk();
        check("stop_pre_pos", 32'(pos_out), 32'd10);
        stop = 1'b1;
        tick_clk();
        check("stop_pos", 32'(pos_out), 32'd10);
        check("stop_busy", 32'(busy), 32'd0);
        check("stop_done", 32'(done), 32'd1);
        check("stop_ready", 32'(bus.cmd_ready), 32'd1);
        stop = 1'b0;
        tick_clk();
        check("stop_done_clr", 32'(done), 32'd0);
        repeat (4) tick_clk();
        check("stop_frozen", 32'(pos_out), 32'd10);

        // Command held during MOVE is taken on the first IDLE cycle
        bus.cmd_valid  = 1'b1;
        bus.cmd_target = 16'd11;
        bus.cmd_off    = 1'b0;
        tick_clk();
        bus.cmd_target = 16'd13;
        for (int k = 1; k <= 3; k++) begin
            tick_clk();
            check($sformatf("hs_ready@%0d", k), 32'(bus.cmd_ready), 32'd0);
            check($sformatf("hs_busy@%0d", k), 32'(busy), 32'd1);
        end
        tick_clk();
        check("hs_idle_pos", 32'(pos_out), 32'd11);
        check("hs_idle_done", 32'(done), 32'd1);
        check("hs_idle_ready", 32'(bus.cmd_ready), 32'd1);
        check("hs_idle_busy", 32'(busy), 32'd0);
        tick_clk();
        check("hs_accept_busy", 32'(busy), 32'd1);
        check("hs_accept_ready", 32'(bus.cmd_ready), 32'd0);
        bus.cmd_valid = 1'b0;
        wait_done(40, cycles, lo, hi);
        check("hs_cycles", 32'(cycles), 32'd8);
        check("hs_pos", 32'(pos_out), 32'd13);

        // Off at position 40, then re-enable at the same position
        issue_cmd(16'd40, 1'b0);
        wait_done(200, cycles, lo, hi);
        check("to40_cycles", 32'(cycles), 32'd108);
        stop = 1'b1;
        tick_clk();
        check("idle_stop_ignored_busy", 32'(busy), 32'd0);
        check("idle_stop_ignored_done", 32'(done), 32'd0);
        stop = 1'b0;
        issue_cmd(16'd0, 1'b1);
        check("off_en", 32'(pwm_en), 32'd0);
        check("off_pos", 32'(pos_out), 32'd40);
        check("off_done", 32'(done), 32'd0);
        check("off_ready", 32'(bus.cmd_ready), 32'd1);
        tick_clk();
        check("off_done_next", 32'(done), 32'd0);
        check("off_pos_next", 32'(pos_out), 32'd40);
        issue_cmd(16'd40, 1'b0);
        check("same_done", 32'(done), 32'd1);
        check("same_en", 32'(pwm_en), 32'd1);
        check("same_busy", 32'(busy), 32'd0);
        check("same_pos", 32'(pos_out), 32'd40);
        tick_clk();
        check("same_done_clr", 32'(done), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation did not complete (t=%0t)", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
